ones_count_checker: RTL and testbench

Self-checking stimulus and response block for the three-input ones-counter family of cells (switch-level, gate-level and behavioural versions). On `start` it drives all eight input combinations in Gray-code order, waits a programmable settle time, samples the cell's two-bit count output and compares it against the expected population count. It reports a pass/fail verdict, a saturating mismatch count and the first failing step. It replaces hand-written stimulus sequences with a reusable on-clock checker that sits beside any cell under test.

---
 rtl/ones_count_checker.sv | 121 ++++++++++++
 tb/tb_ones_count_checker.sv | 184 ++++++++++++++++++
 2 files changed

// File: rtl/ones_count_checker.sv
// Stimulus/response checker for three-input ones-counter cells: walks the eight
// inputs in Gray order, samples the cell's 2-bit count and accumulates a verdict.
`timescale 1ns/1ps
module ones_count_checker #(
  parameter int SETTLE = 3,
  parameter int ERR_W  = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [1:0]       resp,
  output logic [2:0]       stim,
  output logic             busy,
  output logic             done,
  output logic             pass,
  output logic [ERR_W-1:0] err_count,
  output logic [2:0]       fail_step
);

  localparam logic [3:0]       SETTLE_CNT = 4'(SETTLE);
  localparam logic [ERR_W-1:0] ERR_MAX    = '1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state;
  state_t           state_nxt;
  logic [3:0]       settle_cnt;
  logic [2:0]       step;
  logic             accept;
  logic             sample;
  logic             mismatch;
  logic [ERR_W-1:0] err_nxt;

  function automatic logic [2:0] gray_code(input logic [2:0] idx);
    case (idx)
      3'd0:    return 3'b000;
      3'd1:    return 3'b100;
      3'd2:    return 3'b110;
      3'd3:    return 3'b111;
      3'd4:    return 3'b101;
      3'd5:    return 3'b001;
      3'd6:    return 3'b011;
      default: return 3'b010;
    endcase
  endfunction

  function automatic logic [1:0] popcount3(input logic [2:0] v);
    return {1'b0, v[2]} + {1'b0, v[1]} + {1'b0, v[0]};
  endfunction

  function automatic logic [ERR_W-1:0] sat_inc(input logic [ERR_W-1:0] v);
    return (v == ERR_MAX) ? v : v + ERR_W'(1);
  endfunction

  // A start on the DONE cycle is honoured so back-to-back runs lose no cycle.
  assign accept   = start && (state != RUN);
  assign sample   = (state == RUN) && (settle_cnt == 4'd0);
  assign mismatch = sample && (resp != popcount3(gray_code(step)));
  assign err_nxt  = mismatch ? sat_inc(err_count) : err_count;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start) state_nxt = RUN;
      RUN:     if (sample && (step == 3'd7)) state_nxt = DONE;
      DONE:    state_nxt = start ? RUN : IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    busy = (state == RUN);
    done = (state == DONE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      settle_cnt <= 4'd0;
      step       <= 3'd0;
      stim       <= 3'b000;
      pass       <= 1'b0;
      err_count  <= '0;
      fail_step  <= 3'd0;
    end else if (accept) begin
      settle_cnt <= SETTLE_CNT;
      step       <= 3'd0;
      stim       <= 3'b000;
      pass       <= 1'b0;
      err_count  <= '0;
      fail_step  <= 3'd0;
    end else if (state == RUN) begin
      if (settle_cnt != 4'd0) begin
        settle_cnt <= settle_cnt - 4'd1;
      end else begin
        err_count <= err_nxt;
        // Counter never wraps, so zero means no mismatch seen yet this run.
        if (mismatch && (err_count == '0)) fail_step <= step;
        if (step != 3'd7) begin
          step       <= step + 3'd1;
          stim       <= gray_code(step + 3'd1);
          settle_cnt <= SETTLE_CNT;
        end else begin
          stim <= 3'b000;
          pass <= (err_nxt == '0);
        end
      end
    end else begin
      stim <= 3'b000;
    end
  end

endmodule

// File: tb/tb_ones_count_checker.sv
// Directed bench for ones_count_checker: a fault-injectable cell model feeds the
// main instance; a second instance with ERR_W=2 sees a response stuck at 11.
`timescale 1ns/1ps
module tb_ones_count_checker;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       start;
  logic       start2;
  logic [1:0] resp;
  logic [2:0] stim;
  logic       busy, done, pass;
  logic [3:0] err_count;
  logic [2:0] fail_step;
  logic [2:0] stim2;
  logic       busy2, done2, pass2;
  logic [1:0] err_count2;
  logic [2:0] fail_step2;

  int total = 0;
  int bad   = 0;
  int mode  = 0;

  typedef struct packed {
    logic       p;
    logic [3:0] e;
    logic [2:0] f;
  } exp_t;
  exp_t sb[$];

  logic [2:0] gray_tb [8] = '{3'b000, 3'b100, 3'b110, 3'b111,
                              3'b101, 3'b001, 3'b011, 3'b010};
  logic [1:0] pc;

  always #5 clk = ~clk;

  // Cell model: mode 0 correct, 1 = y0 stuck at 0, 2 = y1 stuck at 0.
  assign pc   = 2'($countones(stim));
  assign resp = (mode == 1) ? {pc[1], 1'b0} : (mode == 2) ? {1'b0, pc[0]} : pc;

  ones_count_checker #(.SETTLE(3), .ERR_W(4)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .resp(resp),
    .stim(stim), .busy(busy), .done(done), .pass(pass),
    .err_count(err_count), .fail_step(fail_step)
  );

  ones_count_checker #(.SETTLE(3), .ERR_W(2)) dut2 (
    .clk(clk), .rst_n(rst_n), .start(start2), .resp(2'b11),
    .stim(stim2), .busy(busy2), .done(done2), .pass(pass2),
    .err_count(err_count2), .fail_step(fail_step2)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic pop_compare();
    exp_t e;
    if (sb.size() == 0) begin
      check("sb_empty", 32'd1, 32'd0);
    end else begin
      e = sb.pop_front();
      check("pass", 32'(pass), 32'(e.p));
      check("err_count", 32'(err_count), 32'(e.e));
      check("fail_step", 32'(fail_step), 32'(e.f));
    end
  endtask

  // One full run of the main instance; E0 is the edge after entry (or after the
  // chained start left high by the previous run).
  task automatic run_test(input int m, input logic ep, input logic [3:0] ee,
                          input logic [2:0] ef, input bit pulse, input bit chain,
                          input bit pre_started);
    mode = m;
    sb.push_back('{p: ep, e: ee, f: ef});
    if (!pre_started) begin
      @(negedge clk);
      start = 1'b1;
    end
    @(posedge clk); #1;
    start = 1'b0;
    check("e0_busy", 32'(busy), 32'd1);
    check("e0_stim", 32'(stim), 32'd0);
    check("e0_err_clr", 32'(err_count), 32'd0);
    check("e0_fail_clr", 32'(fail_step), 32'd0);
    check("e0_pass_clr", 32'(pass), 32'd0);
    for (int c = 1; c <= 32; c++) begin
      if (pulse && c == 10) start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      check("done_timing", 32'(done), (c == 32) ? 32'd1 : 32'd0);
      if (c < 32 && (c % 4) == 0) check("stim_step", 32'(stim), 32'(gray_tb[c / 4]));
    end
    check("end_busy", 32'(busy), 32'd0);
    check("end_stim", 32'(stim), 32'd0);
    pop_compare();
    if (chain) begin
      start = 1'b1;
    end else begin
      @(posedge clk); #1;
      check("done_one_cycle", 32'(done), 32'd0);
      check("pass_hold", 32'(pass), 32'(ep));
      check("err_hold", 32'(err_count), 32'(ee));
    end
  endtask

  initial begin
    rst_n  = 1'b0;
    start  = 1'b0;
    start2 = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_stim", 32'(stim), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_pass", 32'(pass), 32'd0);
    check("rst_err", 32'(err_count), 32'd0);
    check("rst_fail", 32'(fail_step), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(posedge clk);

    // Correct cell, with an ignored start pulse at E0+10.
    run_test(0, 1'b1, 4'd0, 3'd0, 1'b1, 1'b0, 1'b0);
    // y0 stuck, then a chained start on the edge after done, then y1 stuck.
    run_test(1, 1'b0, 4'd4, 3'd1, 1'b0, 1'b1, 1'b0);
    run_test(2, 1'b0, 4'd4, 3'd2, 1'b0, 1'b0, 1'b1);
    run_test(0, 1'b1, 4'd0, 3'd0, 1'b0, 1'b0, 1'b0);

    // Saturating counter on the narrow instance.
    @(negedge clk);
    start2 = 1'b1;
    @(posedge clk); #1;
    start2 = 1'b0;
    begin
      int n;
      n = 0;
      while (!done2 && n < 40) begin
        @(posedge clk); #1;
        n++;
      end
      check("sat_latency", 32'(n), 32'd32);
    end
    check("sat_err", 32'(err_count2), 32'd3);
    check("sat_fail", 32'(fail_step2), 32'd0);
    check("sat_pass", 32'(pass2), 32'd0);

    // Reset mid-run with y0 stuck (one mismatch already counted by E0+13).
    mode = 1;
    @(negedge clk);
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (13) @(posedge clk);
    #1;
    check("pre_rst_stim", 32'(stim), 32'(gray_tb[3]));
    check("pre_rst_err", 32'(err_count), 32'd1);
    rst_n = 1'b0;
    #1;
    check("async_stim", 32'(stim), 32'd0);
    check("async_busy", 32'(busy), 32'd0);
    check("async_err", 32'(err_count), 32'd0);
    check("async_fail", 32'(fail_step), 32'd0);
    for (int c = 0; c < 24; c++) begin
      @(posedge clk); #1;
      check("no_done_in_rst", 32'(done), 32'd0);
    end
    @(negedge clk);
    rst_n = 1'b1;
    repeat (40) @(posedge clk);
    #1;
    check("idle_after_rst", 32'(busy), 32'd0);
    run_test(0, 1'b1, 4'd0, 3'd0, 1'b0, 1'b0, 1'b0);

    check("sb_drained", 32'(sb.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
